// File: rtl/mini_core_rf_mp_pkg.sv
// mini_core_rf_mp_pkg: shared limits for the multi-port register file.
// The request structs are declared inside mini_core_rf_mp_if because their widths follow the instance parameters.
package mini_core_rf_mp_pkg;

    localparam int RF_MP_MAX_WR_PORTS = 2;
    localparam int RF_MP_MAX_RD_PORTS = 4;

endpackage

// File: rtl/mini_core_rf_mp_if.sv
// mini_core_rf_mp_if: decode/writeback bundle for mini_core_rf_mp.
// The master side drives requests and the slave side is the register file.
// ParityErrQ102H exists only when MINI_CORE_RF_PARITY_EN is defined.
interface mini_core_rf_mp_if #(
    parameter int NUM_REGS     = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int NUM_RD_PORTS = 2,
    parameter int NUM_WR_PORTS = 1
);
    localparam int ADDR_W = $clog2(NUM_REGS);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
    } t_rf_mp_rd_req;

    typedef struct packed {
        logic                  en;
        logic [ADDR_W-1:0]     addr;
        logic [DATA_WIDTH-1:0] data;
    } t_rf_mp_wr_req;

    logic                                    ready_q102h;
    t_rf_mp_rd_req [NUM_RD_PORTS-1:0]        rd_req_q101h;
    logic [NUM_RD_PORTS-1:0][DATA_WIDTH-1:0] rd_data_q102h;
    t_rf_mp_wr_req [NUM_WR_PORTS-1:0]        wr_req_q104h;
    logic                                    pend_set_q101h;
    logic [ADDR_W-1:0]                       pend_dst_q101h;
    logic                                    hazard_q101h;
    logic [NUM_REGS-1:0]                     pending_vec;
`ifdef MINI_CORE_RF_PARITY_EN
    logic [NUM_RD_PORTS-1:0]                 parity_err_q102h;
`endif

    modport master (
        output ready_q102h, rd_req_q101h, wr_req_q104h, pend_set_q101h, pend_dst_q101h,
        input  rd_data_q102h, hazard_q101h, pending_vec
`ifdef MINI_CORE_RF_PARITY_EN
        , input parity_err_q102h
`endif
    );

    modport slave (
        input  ready_q102h, rd_req_q101h, wr_req_q104h, pend_set_q101h, pend_dst_q101h,
        output rd_data_q102h, hazard_q101h, pending_vec
`ifdef MINI_CORE_RF_PARITY_EN
        , output parity_err_q102h
`endif
    );

endinterface

// File: rtl/mini_core_rf_scoreboard.sv
// mini_core_rf_scoreboard: pending-write bits per register plus the advisory Q101H read hazard.
// A writeback clears a bit, an issuing producer sets it, and set beats clear since the newer producer is still in flight.
module mini_core_rf_scoreboard #(
    parameter int NUM_REGS     = 32,
    parameter int NUM_RD_PORTS = 2,
    parameter int NUM_WR_PORTS = 1,
    localparam int ADDR_W      = $clog2(NUM_REGS)
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                pend_set,
    input  logic [ADDR_W-1:0]                   pend_dst,
    input  logic [NUM_WR_PORTS-1:0]             wr_en,
    input  logic [NUM_WR_PORTS-1:0][ADDR_W-1:0] wr_addr,
    input  logic [NUM_RD_PORTS-1:0][ADDR_W-1:0] rd_addr,
    output logic                                hazard,
    output logic [NUM_REGS-1:0]                 pending_vec
);
    logic [NUM_REGS-1:0] clr;
    logic [NUM_REGS-1:0] pending_d, pending_q;

    // registers being written back this cycle
    always_comb begin
        clr = '0;
        for (int p = 0; p < NUM_WR_PORTS; p++)
            if (wr_en[p]) clr[wr_addr[p]] = 1'b1;
    end

    // clear on writeback, then set from issue so set wins; reg 0 never pends
    always_comb begin
        pending_d = pending_q & ~clr;
        if (pend_set) pending_d[pend_dst] = 1'b1;
        pending_d[0] = 1'b0;
    end

    // a source is hazardous only if pending and not resolved by this cycle's bypass
    always_comb begin
        hazard = 1'b0;
        for (int r = 0; r < NUM_RD_PORTS; r++)
            if (rd_addr[r] != '0 && pending_q[rd_addr[r]] && !clr[rd_addr[r]]) hazard = 1'b1;
    end

    // scoreboard state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pending_q <= '0;
        else        pending_q <= pending_d;
    end

    assign pending_vec = pending_q;

endmodule

// File: rtl/mini_core_rf_mp.sv
// mini_core_rf_mp: multi-port integer register file with write->read bypass, Q102H output stage and scoreboard.
// Optional MINI_CORE_RF_PARITY_EN: each entry carries an even-parity bit and corrupted stored reads raise ParityErrQ102H.
module mini_core_rf_mp
    import mini_core_rf_mp_pkg::*;
#(
    parameter int NUM_REGS     = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int NUM_RD_PORTS = 2,
    parameter int NUM_WR_PORTS = 1
) (
    input logic           clk,
    input logic           rst_n,
    mini_core_rf_mp_if.slave bus
);
    localparam int ADDR_W = $clog2(NUM_REGS);
`ifdef MINI_CORE_RF_PARITY_EN
    localparam int ENTRY_W = DATA_WIDTH + 1;
`else
    localparam int ENTRY_W = DATA_WIDTH;
`endif

    logic [ENTRY_W-1:0]                      regs_d [NUM_REGS];
    logic [ENTRY_W-1:0]                      regs_q [NUM_REGS];
    logic [NUM_RD_PORTS-1:0][DATA_WIDTH-1:0] rd_val;
    logic [NUM_RD_PORTS-1:0][DATA_WIDTH-1:0] rd_data_d, rd_data_q;
    logic [NUM_RD_PORTS-1:0][ADDR_W-1:0]     rd_addr;
    logic [NUM_WR_PORTS-1:0]                 wr_en;
    logic [NUM_WR_PORTS-1:0][ADDR_W-1:0]     wr_addr;

    function automatic logic [ENTRY_W-1:0] encode(input logic [DATA_WIDTH-1:0] d);
`ifdef MINI_CORE_RF_PARITY_EN
        return {^d, d};
`else
        return d;
`endif
    endfunction

    // flatten the request structs for indexing and for the scoreboard
    always_comb begin
        for (int r = 0; r < NUM_RD_PORTS; r++) rd_addr[r] = bus.rd_req_q101h[r].addr;
        for (int p = 0; p < NUM_WR_PORTS; p++) begin
            wr_en[p]   = bus.wr_req_q104h[p].en;
            wr_addr[p] = bus.wr_req_q104h[p].addr;
        end
    end

    // writeback update; later ports overwrite earlier ones so the highest index wins, reg 0 stays zero
    always_comb begin
        regs_d = regs_q;
        for (int p = 0; p < NUM_WR_PORTS; p++)
            if (wr_en[p] && wr_addr[p] != '0) regs_d[wr_addr[p]] = encode(bus.wr_req_q104h[p].data);
    end

    // Q101H read with same-cycle bypass from the highest matching write port
    always_comb begin
        for (int r = 0; r < NUM_RD_PORTS; r++) begin
            rd_val[r] = regs_q[rd_addr[r]][DATA_WIDTH-1:0];
            for (int p = 0; p < NUM_WR_PORTS; p++)
                if (wr_en[p] && wr_addr[p] == rd_addr[r]) rd_val[r] = bus.wr_req_q104h[p].data;
            if (rd_addr[r] == '0) rd_val[r] = '0;
        end
    end

    // Q102H capture under ready, hold otherwise
    always_comb rd_data_d = bus.ready_q102h ? rd_val : rd_data_q;

    // storage and output stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q    <= '{default: '0};
            rd_data_q <= '0;
        end else begin
            regs_q    <= regs_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign bus.rd_data_q102h = rd_data_q;

`ifdef MINI_CORE_RF_PARITY_EN
    logic [NUM_RD_PORTS-1:0] perr_d, perr_q;

    // stored reads with odd total parity are corrupt; bypassed and reg-0 reads never flag
    always_comb begin
        perr_d = perr_q;
        if (bus.ready_q102h) begin
            for (int r = 0; r < NUM_RD_PORTS; r++) begin
                perr_d[r] = (rd_addr[r] != '0) && (^regs_q[rd_addr[r]]);
                for (int p = 0; p < NUM_WR_PORTS; p++)
                    if (wr_en[p] && wr_addr[p] == rd_addr[r]) perr_d[r] = 1'b0;
            end
        end
    end

    // parity error output stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) perr_q <= '0;
        else        perr_q <= perr_d;
    end

    assign bus.parity_err_q102h = perr_q;
`endif

    mini_core_rf_scoreboard #(
        .NUM_REGS     (NUM_REGS),
        .NUM_RD_PORTS (NUM_RD_PORTS),
        .NUM_WR_PORTS (NUM_WR_PORTS)
    ) u_scoreboard (
        .clk         (clk),
        .rst_n       (rst_n),
        .pend_set    (bus.pend_set_q101h),
        .pend_dst    (bus.pend_dst_q101h),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .rd_addr     (rd_addr),
        .hazard      (bus.hazard_q101h),
        .pending_vec (bus.pending_vec)
    );

endmodule

// File: tb/tb_mini_core_rf_mp.sv
// tb_mini_core_rf_mp: scoreboard bench for mini_core_rf_mp with two read and two write ports.
module tb_mini_core_rf_mp;
    localparam int NR  = 32;
    localparam int DW  = 32;
    localparam int NRD = 2;
    localparam int NWR = 2;
    localparam int AW  = 5;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mini_core_rf_mp_if #(.NUM_REGS(NR), .DATA_WIDTH(DW), .NUM_RD_PORTS(NRD), .NUM_WR_PORTS(NWR)) bus ();

    mini_core_rf_mp #(.NUM_REGS(NR), .DATA_WIDTH(DW), .NUM_RD_PORTS(NRD), .NUM_WR_PORTS(NWR)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int n_chk = 0;
    int n_err = 0;
    logic [DW-1:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        bus.ready_q102h    = 1'b1;
        bus.pend_set_q101h = 1'b0;
        bus.pend_dst_q101h = '0;
        for (int r = 0; r < NRD; r++) bus.rd_req_q101h[r].addr = '0;
        for (int p = 0; p < NWR; p++) begin
            bus.wr_req_q104h[p].en   = 1'b0;
            bus.wr_req_q104h[p].addr = '0;
            bus.wr_req_q104h[p].data = '0;
        end
    endtask

    task automatic wr(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.wr_req_q104h[p].en   = 1'b1;
        bus.wr_req_q104h[p].addr = a;
        bus.wr_req_q104h[p].data = d;
    endtask

    task automatic rd_push(input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                           input logic [DW-1:0] e0, input logic [DW-1:0] e1);
        bus.rd_req_q101h[0].addr = a0;
        bus.rd_req_q101h[1].addr = a1;
        exp_q.push_back(e0);
        exp_q.push_back(e1);
    endtask

    task automatic rd_pop(input string tag);
        for (int r = 0; r < NRD; r++) begin
            if (exp_q.size() == 0) check({tag, "_underflow"}, 64'd0, 64'd1);
            else check($sformatf("%s_p%0d", tag, r), 64'(bus.rd_data_q102h[r]), 64'(exp_q.pop_front()));
        end
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_rd0", 64'(bus.rd_data_q102h[0]), 64'd0);
        check("rst_rd1", 64'(bus.rd_data_q102h[1]), 64'd0);
        check("rst_pend", 64'(bus.pending_vec), 64'd0);
        rst_n = 1'b1;
        tick();

        wr(0, 5'd5, 32'hDEAD_BEEF);
        tick();
        idle();
        rd_push(5'd5, 5'd0, 32'hDEAD_BEEF, 32'd0);
        tick();
        idle();
        rd_pop("rd5");

        wr(0, 5'd7, 32'h1234);
        rd_push(5'd7, 5'd7, 32'h1234, 32'h1234);
        tick();
        idle();
        rd_pop("byp7");

        wr(0, 5'd0, 32'hFFFF);
        rd_push(5'd0, 5'd0, 32'd0, 32'd0);
        tick();
        idle();
        rd_pop("byp0");

        rd_push(5'd0, 5'd7, 32'd0, 32'h1234);
        tick();
        idle();
        rd_pop("stored0_7");

        wr(0, 5'd3, 32'd1);
        wr(1, 5'd3, 32'd2);
        tick();
        idle();
        rd_push(5'd3, 5'd5, 32'd2, 32'hDEAD_BEEF);
        tick();
        idle();
        rd_pop("dual3");

        wr(0, 5'd4, 32'hAA);
        wr(1, 5'd4, 32'hBB);
        rd_push(5'd4, 5'd4, 32'hBB, 32'hBB);
        tick();
        idle();
        rd_pop("dualbyp4");

        bus.ready_q102h = 1'b0;
        bus.rd_req_q101h[0].addr = 5'd5;
        bus.rd_req_q101h[1].addr = 5'd7;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("stall%0d_p0", i), 64'(bus.rd_data_q102h[0]), 64'hBB);
            check($sformatf("stall%0d_p1", i), 64'(bus.rd_data_q102h[1]), 64'hBB);
        end
        bus.ready_q102h = 1'b1;
        rd_push(5'd5, 5'd7, 32'hDEAD_BEEF, 32'h1234);
        tick();
        idle();
        rd_pop("unstall");

        bus.pend_set_q101h = 1'b1;
        bus.pend_dst_q101h = 5'd9;
        tick();
        idle();
        check("pend9", 64'(bus.pending_vec), 64'h200);
        rd_push(5'd9, 5'd0, 32'h99, 32'd0);
        #1;
        check("haz9", 64'(bus.hazard_q101h), 64'd1);
        wr(0, 5'd9, 32'h99);
        #1;
        check("haz9_byp", 64'(bus.hazard_q101h), 64'd0);
        tick();
        idle();
        rd_pop("byp9");
        check("pend9_clr", 64'(bus.pending_vec), 64'd0);

        bus.pend_set_q101h = 1'b1;
        bus.pend_dst_q101h = 5'd9;
        tick();
        idle();
        bus.rd_req_q101h[1].addr = 5'd9;
        #1;
        check("haz9_p1", 64'(bus.hazard_q101h), 64'd1);
        bus.pend_set_q101h = 1'b1;
        bus.pend_dst_q101h = 5'd9;
        wr(1, 5'd9, 32'h77);
        tick();
        idle();
        check("set_wins", 64'(bus.pending_vec), 64'h200);

        bus.pend_set_q101h = 1'b1;
        bus.pend_dst_q101h = 5'd0;
        wr(0, 5'd2, 32'h5);
        tick();
        idle();
        check("pend0_ign", 64'(bus.pending_vec), 64'h200);
        bus.rd_req_q101h[0].addr = 5'd2;
        #1;
        check("haz_clean", 64'(bus.hazard_q101h), 64'd0);

        rd_push(5'd9, 5'd3, 32'h77, 32'd2);
        tick();
        idle();
        rd_pop("pre_rst");

        wr(0, 5'd20, 32'h55);
        bus.pend_set_q101h = 1'b1;
        bus.pend_dst_q101h = 5'd11;
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_rd0", 64'(bus.rd_data_q102h[0]), 64'd0);
        check("midrst_rd1", 64'(bus.rd_data_q102h[1]), 64'd0);
        check("midrst_pend", 64'(bus.pending_vec), 64'd0);
        tick();
        idle();
        rst_n = 1'b1;
        rd_push(5'd20, 5'd5, 32'd0, 32'd0);
        tick();
        idle();
        rd_pop("post_rst_a");
        rd_push(5'd9, 5'd3, 32'd0, 32'd0);
        tick();
        idle();
        rd_pop("post_rst_b");

`ifdef MINI_CORE_RF_PARITY_EN
        wr(0, 5'd12, 32'hF0);
        wr(1, 5'd13, 32'h1);
        tick();
        idle();
        dut.regs_q[12][4] = ~dut.regs_q[12][4];
        rd_push(5'd12, 5'd13, 32'hE0, 32'h1);
        tick();
        idle();
        rd_pop("par_data");
        check("par_err", 64'(bus.parity_err_q102h), 64'd1);
`endif

        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
